weight_loader: RTL

WEIGHT_LOADER -- requirements
Module: weight_loader

---
 rtl/weight_loader_pkg.sv | 14 +
 rtl/weight_loader_neuron_sel_decoder.sv | 18 +
 rtl/weight_loader.sv | 127 ++++++++++++
 3 files changed

// File: rtl/weight_loader_pkg.sv
// Shared definitions for the MLP weight loader blocks:
// loader state encodings and the default header index field width.
package weight_loader_pkg;

   localparam int HDR_IDX_W = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_SKIP = 2'd2,
      S_DONE = 2'd3
   } wl_state_t;

endpackage

// File: rtl/weight_loader_neuron_sel_decoder.sv
// One-hot neuron select: bit i is set when idx equals i.
// Indices at or above numNeurons decode to all zeros.
module neuron_sel_decoder #(
   parameter int idxWidth   = 8,
   parameter int numNeurons = 4
) (
   input  logic [idxWidth-1:0]   idx,
   output logic [numNeurons-1:0] onehot
);

   always_comb begin
      onehot = '0;
      for (int i = 0; i < numNeurons; i++) begin
         onehot[i] = (idx == idxWidth'(i));
      end
   end

endmodule

// File: rtl/weight_loader.sv
// Streams a header plus numWeight weight words into one of
// numNeurons weight memories through a registered write port.
module weight_loader
   import weight_loader_pkg::*;
#(
   parameter int numWeight    = 3,
   parameter int numNeurons   = 4,
   parameter int layerNo      = 1,
   parameter int addressWidth = 10,
   parameter int dataWidth    = 16,
   parameter int idxWidth     = HDR_IDX_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    s_valid,
   input  logic [dataWidth-1:0]    s_data,
   output logic                    s_ready,
   output logic [numNeurons-1:0]   wen,
   output logic [addressWidth-1:0] wadd,
   output logic [dataWidth-1:0]    win,
   output logic                    load_done,
   output logic                    hdr_err,
   output logic                    busy
);

   localparam int CNT_W = (numWeight > 1) ? $clog2(numWeight) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(numWeight - 1);
   localparam logic [31:0] NN = 32'(numNeurons);

   wl_state_t state, state_nxt;
   logic [idxWidth-1:0] idx, idx_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [idxWidth-1:0] hdr_idx;
   logic [numNeurons-1:0] sel;
   logic xfer;
   logic wr_nxt;
   logic done_nxt;
   logic err_nxt;

   assign xfer    = s_valid && s_ready;
   assign hdr_idx = s_data[idxWidth-1:0];

   neuron_sel_decoder #(
      .idxWidth  (idxWidth),
      .numNeurons(numNeurons)
   ) u_dec (
      .idx   (idx),
      .onehot(sel)
   );

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = cnt;
      wr_nxt    = 1'b0;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (xfer) begin
               idx_nxt = hdr_idx;
               cnt_nxt = '0;
               if (32'(hdr_idx) < NN) begin
                  state_nxt = S_LOAD;
               end else begin
                  state_nxt = S_SKIP;
                  err_nxt   = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (xfer) begin
               wr_nxt = 1'b1;
               if (cnt == CNT_LAST) begin
                  state_nxt = S_DONE;
                  done_nxt  = 1'b1;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         S_SKIP: begin
            if (xfer) begin
               if (cnt == CNT_LAST) begin
                  state_nxt = S_IDLE;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs follow the next state so they line up with the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         idx       <= '0;
         cnt       <= '0;
         wen       <= '0;
         wadd      <= '0;
         win       <= '0;
         load_done <= 1'b0;
         hdr_err   <= 1'b0;
         busy      <= 1'b0;
         s_ready   <= 1'b0;
      end else begin
         state     <= state_nxt;
         idx       <= idx_nxt;
         cnt       <= cnt_nxt;
         wen       <= wr_nxt ? sel : '0;
         load_done <= done_nxt;
         hdr_err   <= err_nxt;
         busy      <= (state_nxt != S_IDLE);
         s_ready   <= (state_nxt != S_DONE);
         if (wr_nxt) begin
            wadd <= addressWidth'(cnt);
            win  <= s_data;
         end
      end
   end

endmodule
